// File: rtl/card_tile_painter.sv
// Per-card pixel generator: raster-scans one bordered card rectangle, one pixel
// write per clock, painting the card face or the card back depending on face state.
module card_tile_painter #(
    parameter int unsigned XOFFSET      = 70,
    parameter int unsigned YOFFSET      = 50,
    parameter int unsigned OBJ_W        = 40,
    parameter int unsigned OBJ_H        = 40,
    parameter int unsigned BORDER       = 2,
    parameter int unsigned COLOR_DEPTH  = 6,
    parameter logic [COLOR_DEPTH-1:0] BACK_COLOR   = COLOR_DEPTH'(6'b000011),
    parameter logic [COLOR_DEPTH-1:0] BORDER_COLOR = '1
) (
    input  logic                   CLOCK_50,
    input  logic                   Reset,
    input  logic                   go,
    input  logic                   flip,
    input  logic [COLOR_DEPTH-1:0] face_color,
    output logic [9:0]             VGA_x,
    output logic [8:0]             VGA_y,
    output logic [COLOR_DEPTH-1:0] VGA_color,
    output logic                   VGA_write,
    output logic                   done,
    output logic                   busy,
    output logic                   face_up
);

    localparam logic [9:0] X_LAST   = 10'(OBJ_W - 1);
    localparam logic [8:0] Y_LAST   = 9'(OBJ_H - 1);
    localparam logic [9:0] X_BORDER = 10'(BORDER);
    localparam logic [8:0] Y_BORDER = 9'(BORDER);
    localparam logic [9:0] X_INNER  = 10'(OBJ_W - BORDER);
    localparam logic [8:0] Y_INNER  = 9'(OBJ_H - BORDER);
    localparam logic [9:0] X_BASE   = 10'(XOFFSET);
    localparam logic [8:0] Y_BASE   = 9'(YOFFSET);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_DONE
    } state_t;

    state_t                 state;
    logic [9:0]             cx;
    logic [8:0]             cy;
    logic                   draw_face;
    logic [COLOR_DEPTH-1:0] col;

    logic                   face_next;
    logic                   last_pix;
    logic [9:0]             nx;
    logic [8:0]             ny;

    // Colour of card-relative pixel (x,y) for a given face state and face colour.
    function automatic logic [COLOR_DEPTH-1:0] pix_color(
        input logic [9:0]             x,
        input logic [8:0]             y,
        input logic                   face,
        input logic [COLOR_DEPTH-1:0] c
    );
        logic on_border;
        on_border = (x < X_BORDER) || (x >= X_INNER) || (y < Y_BORDER) || (y >= Y_INNER);
        if (on_border)
            return BORDER_COLOR;
        else if (face)
            return c;
        else
            return BACK_COLOR;
    endfunction

    // Post-flip face state and next raster position.
    always_comb begin
        face_next = face_up ^ flip;
        last_pix  = (cx == X_LAST) && (cy == Y_LAST);
        nx        = cx + 10'd1;
        ny        = cy;
        if (cx == X_LAST) begin
            nx = '0;
            ny = cy + 9'd1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state     <= S_IDLE;
            cx        <= '0;
            cy        <= '0;
            draw_face <= 1'b0;
            col       <= '0;
            VGA_x     <= '0;
            VGA_y     <= '0;
            VGA_color <= '0;
            VGA_write <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            face_up   <= 1'b0;
        end else begin
            face_up   <= face_next;
            done      <= 1'b0;
            VGA_write <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state     <= S_DRAW;
                        busy      <= 1'b1;
                        draw_face <= face_next;
                        col       <= face_color;
                        cx        <= '0;
                        cy        <= '0;
                        VGA_write <= 1'b1;
                        VGA_x     <= X_BASE;
                        VGA_y     <= Y_BASE;
                        VGA_color <= pix_color(10'd0, 9'd0, face_next, face_color);
                    end
                end
                S_DRAW: begin
                    if (last_pix) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cx        <= nx;
                        cy        <= ny;
                        VGA_write <= 1'b1;
                        VGA_x     <= X_BASE + nx;
                        VGA_y     <= Y_BASE + ny;
                        VGA_color <= pix_color(nx, ny, draw_face, col);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
